// File: rtl/nibble_serial_sub16.sv
// Digit-serial subtractor: A - B - B_in, one DIGIT-bit slice per clock, LSD first.
// Define SUB_OVF_EN to add the signed-overflow output V.
module nibble_serial_sub16 #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             B_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             B_out
`ifdef SUB_OVF_EN
  ,
  output logic             V
`endif
);

  localparam int N  = WIDTH / DIGIT;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_d;
  logic             r_bw;
  logic [KW-1:0]    r_k;
  logic             r_busy;
  logic             r_done;
  logic             r_bout;
  logic             r_v;

  logic [DIGIT-1:0] w_a_dig;
  logic [DIGIT-1:0] w_b_dig;
  logic [DIGIT:0]   w_sub;
  logic             w_last;

  // One subtract slice; the extra MSB of the result is the outgoing borrow.
  function automatic logic [DIGIT:0] sub_digit(input logic [DIGIT-1:0] a,
                                               input logic [DIGIT-1:0] b,
                                               input logic             bin);
    return {1'b0, a} - {1'b0, b} - {{DIGIT{1'b0}}, bin};
  endfunction

  assign w_a_dig = r_a[r_k*DIGIT +: DIGIT];
  assign w_b_dig = r_b[r_k*DIGIT +: DIGIT];
  assign w_sub   = sub_digit(w_a_dig, w_b_dig, r_bw);
  assign w_last  = (r_k == KW'(N - 1));

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_d     <= '0;
      r_bw    <= 1'b0;
      r_k     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_bout  <= 1'b0;
      r_v     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= A;
            r_b     <= B;
            r_bw    <= B_in;
            r_d     <= '0;
            r_k     <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_d[r_k*DIGIT +: DIGIT] <= w_sub[DIGIT-1:0];
          r_bw <= w_sub[DIGIT];
          r_k  <= r_k + 1'b1;
          if (w_last) begin
            // Top digit just produced: its MSB is the sign of the finished result.
            r_bout  <= w_sub[DIGIT];
            r_v     <= (r_a[WIDTH-1] != r_b[WIDTH-1]) &
                       (w_sub[DIGIT-1] != r_a[WIDTH-1]);
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_k     <= '0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy  = r_busy;
  assign done  = r_done;
  assign D     = r_d;
  assign B_out = r_bout;
`ifdef SUB_OVF_EN
  assign V     = r_v;
`else
  logic w_unused_v;
  assign w_unused_v = r_v;
`endif

endmodule

// File: tb/tb_nibble_serial_sub16.sv
// Self-checking bench for nibble_serial_sub16 against an arithmetic reference model.
module tb_nibble_serial_sub16;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        start = 1'b0;
  logic [15:0] A = '0;
  logic [15:0] B = '0;
  logic        B_in = 1'b0;
  logic        busy;
  logic        done;
  logic [15:0] D;
  logic        B_out;
`ifdef SUB_OVF_EN
  logic        V;
`endif

  int errors = 0;
  int checks = 0;

  nibble_serial_sub16 #(.WIDTH(16), .DIGIT(4)) dut (
    .CLK(CLK), .RST(RST), .start(start), .A(A), .B(B), .B_in(B_in),
    .busy(busy), .done(done), .D(D), .B_out(B_out)
`ifdef SUB_OVF_EN
    , .V(V)
`endif
  );

  always #5 CLK = ~CLK;

  function automatic logic [16:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic bin);
    return {1'b0, a} - {1'b0, b} - {16'd0, bin};
  endfunction

  function automatic logic model_v(input logic [15:0] a, input logic [15:0] b,
                                   input logic bin);
    logic [16:0] r;
    r = model(a, b, bin);
    return (a[15] != b[15]) && (r[15] != a[15]);
  endfunction

  // Waits (bounded) for done, sampling at falling edges; reports cycles and busy count.
  task automatic wait_done(output int lat, output int busy_cnt);
    lat = 0;
    busy_cnt = 0;
    while (!done && lat < 20) begin
      if (busy) busy_cnt++;
      @(negedge CLK);
      lat++;
    end
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic bin,
                        output int lat, output int busy_cnt);
    @(negedge CLK);
    A = a; B = b; B_in = bin; start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    wait_done(lat, busy_cnt);
  endtask

  task automatic test_reset;
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0)  begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (D !== 16'h0)    begin errors++; $display("FAIL reset_D got=%h exp=0000", D); end
    checks++; if (B_out !== 1'b0) begin errors++; $display("FAIL reset_bout got=%b exp=0", B_out); end
`ifdef SUB_OVF_EN
    checks++; if (V !== 1'b0)     begin errors++; $display("FAIL reset_V got=%b exp=0", V); end
`endif
    RST = 1'b0;
    // Reset and start together: reset wins.
    @(negedge CLK);
    RST = 1'b1; start = 1'b1; A = 16'h1111; B = 16'h0001;
    @(negedge CLK);
    RST = 1'b0; start = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_start_busy got=%b exp=0", busy); end
  endtask

  task automatic test_directed;
    int lat, bc;
    run_op(16'h1234, 16'h0234, 1'b0, lat, bc);
    checks++; if (lat !== 4)       begin errors++; $display("FAIL lat1 got=%0d exp=4", lat); end
    checks++; if (bc !== 4)        begin errors++; $display("FAIL busy_cycles got=%0d exp=4", bc); end
    checks++; if (D !== 16'h1000)  begin errors++; $display("FAIL d1 got=%h exp=1000", D); end
    checks++; if (B_out !== 1'b0)  begin errors++; $display("FAIL bout1 got=%b exp=0", B_out); end
    checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL busy_at_done got=%b exp=0", busy); end
    @(negedge CLK);
    checks++; if (done !== 1'b0)   begin errors++; $display("FAIL done_pulse got=%b exp=0", done); end
    run_op(16'h0000, 16'h0001, 1'b0, lat, bc);
    checks++; if (D !== 16'hFFFF)  begin errors++; $display("FAIL ripple_d got=%h exp=ffff", D); end
    checks++; if (B_out !== 1'b1)  begin errors++; $display("FAIL ripple_bout got=%b exp=1", B_out); end
    repeat (3) @(negedge CLK);
    checks++; if (D !== 16'hFFFF)  begin errors++; $display("FAIL hold_d got=%h exp=ffff", D); end
    checks++; if (B_out !== 1'b1)  begin errors++; $display("FAIL hold_bout got=%b exp=1", B_out); end
    run_op(16'h8000, 16'h0001, 1'b0, lat, bc);
    checks++; if (D !== 16'h7FFF)  begin errors++; $display("FAIL ovf_d got=%h exp=7fff", D); end
    checks++; if (B_out !== 1'b0)  begin errors++; $display("FAIL ovf_bout got=%b exp=0", B_out); end
`ifdef SUB_OVF_EN
    checks++; if (V !== 1'b1)      begin errors++; $display("FAIL ovf_v got=%b exp=1", V); end
`endif
    run_op(16'h0010, 16'h000F, 1'b1, lat, bc);
    checks++; if (D !== 16'h0000)  begin errors++; $display("FAIL bin_d got=%h exp=0000", D); end
    checks++; if (B_out !== 1'b0)  begin errors++; $display("FAIL bin_bout got=%b exp=0", B_out); end
`ifdef SUB_OVF_EN
    checks++; if (V !== 1'b0)      begin errors++; $display("FAIL bin_v got=%b exp=0", V); end
`endif
  endtask

  task automatic test_ignore_start;
    int lat, bc;
    @(negedge CLK);
    A = 16'h5A5A; B = 16'h1234; B_in = 1'b1; start = 1'b1;
    @(negedge CLK);
    A = 16'hFFFF; B = 16'hFFFF; B_in = 1'b0;
    @(negedge CLK);
    start = 1'b0;
    A = 16'h0000; B = 16'h0000;
    wait_done(lat, bc);
    checks++; if (lat !== 3)      begin errors++; $display("FAIL ign_lat got=%0d exp=3", lat); end
    checks++; if (D !== 16'h4825) begin errors++; $display("FAIL ign_d got=%h exp=4825", D); end
    @(negedge CLK);
    checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL ign_requeue got=%b exp=0", busy); end
  endtask

  task automatic test_back_to_back;
    int lat, bc;
    logic [16:0] exp;
    run_op(16'h0100, 16'h0001, 1'b0, lat, bc);
    checks++; if (D !== 16'h00FF) begin errors++; $display("FAIL b2b_first got=%h exp=00ff", D); end
    A = 16'h0003; B = 16'h0005; B_in = 1'b1; start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    wait_done(lat, bc);
    exp = model(16'h0003, 16'h0005, 1'b1);
    checks++; if (lat !== 4)      begin errors++; $display("FAIL b2b_lat got=%0d exp=4", lat); end
    checks++; if ({B_out, D} !== exp) begin errors++; $display("FAIL b2b_res got=%h exp=%h", {B_out, D}, exp); end
  endtask

  task automatic test_rst_mid;
    int lat, bc;
    run_op(16'h0000, 16'h0001, 1'b0, lat, bc);
    @(negedge CLK);
    A = 16'h9999; B = 16'h1111; start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL mid_busy got=%b exp=0", busy); end
    checks++; if (D !== 16'h0)    begin errors++; $display("FAIL mid_d got=%h exp=0000", D); end
    checks++; if (B_out !== 1'b0) begin errors++; $display("FAIL mid_bout got=%b exp=0", B_out); end
    bc = 0;
    repeat (6) begin @(negedge CLK); if (done) bc++; end
    checks++; if (bc !== 0)       begin errors++; $display("FAIL mid_nodone got=%0d exp=0", bc); end
    run_op(16'hFFFF, 16'hFFFF, 1'b0, lat, bc);
    checks++; if (D !== 16'h0000) begin errors++; $display("FAIL post_rst_d got=%h exp=0000", D); end
    checks++; if (B_out !== 1'b0) begin errors++; $display("FAIL post_rst_bout got=%b exp=0", B_out); end
  endtask

  task automatic test_random;
    int lat, bc;
    logic [15:0] a, b;
    logic        bin;
    logic [16:0] exp;
    for (int i = 0; i < 10000; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      bin = 1'($urandom);
      exp = model(a, b, bin);
      run_op(a, b, bin, lat, bc);
      checks++;
      if (lat !== 4 || {B_out, D} !== exp) begin
        errors++;
        $display("FAIL rand a=%h b=%h bin=%b got=%h lat=%0d exp=%h lat=4", a, b, bin, {B_out, D}, lat, exp);
      end
`ifdef SUB_OVF_EN
      checks++;
      if (V !== model_v(a, b, bin)) begin
        errors++;
        $display("FAIL rand_v a=%h b=%h bin=%b got=%b exp=%b", a, b, bin, V, model_v(a, b, bin));
      end
`endif
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_ignore_start;
    test_back_to_back;
    test_rst_mid;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
